// File: rtl/rob_pkg.sv
// Shared ROB definitions used by dispatch, commit and the reservation stations.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;
    localparam int ROB_DEPTH = 8;
    localparam int NREG      = 32;
    localparam int TW        = $clog2(ROB_DEPTH);
    localparam int RW        = $clog2(NREG);

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
    } rename_t;
endpackage

// File: rtl/rob_dispatch_rename_table.sv
// Register rename table: maps each architectural register to its in-flight ROB tag.
// Latency: reads combinational, set/clear visible the edge after they are applied.
// Backpressure: none; always accepts set/clear/flush.
// Ports: 2 read ports (rd_idx*/rd_dat*), set port (set_*), conditional clear
// (clr_*, only when stored tag matches clr_tag), flush clears every valid bit.
module rename_table
    import rob_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] rd_idx1,
    input  logic [RW-1:0] rd_idx2,
    output rename_t       rd_dat1,
    output rename_t       rd_dat2,
    input  logic          set_en,
    input  logic [RW-1:0] set_idx,
    input  logic [TW-1:0] set_tag,
    input  logic          clr_en,
    input  logic [RW-1:0] clr_idx,
    input  logic [TW-1:0] clr_tag,
    input  logic          flush
);
    rename_t tbl [NREG];

    assign rd_dat1 = tbl[rd_idx1];
    assign rd_dat2 = tbl[rd_idx2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) tbl[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) tbl[i] <= '0;
        end else begin
            // Only drop the mapping if no younger producer has replaced it.
            if (clr_en && tbl[clr_idx].tag == clr_tag) tbl[clr_idx].valid <= 1'b0;
            // Placed after the clear so a same-register dispatch overrides it.
            if (set_en) tbl[set_idx] <= '{valid: 1'b1, tag: set_tag};
        end
    end
endmodule

// File: rtl/rob_dispatch.sv
// ROB allocation/rename: assigns tail tags, renames dests, resolves source readiness.
// Latency: one cycle from dispatch handshake to registered rs_* packet.
// Backpressure: disp_ready low when ROB full or flushing; commit never bypasses a full ROB.
// Ports: disp_* in-order instruction input, cmt_valid head retire pulse, flush,
// rs_* registered packet to the reservation stations, rob_* status registers.
module rob_dispatch
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
    parameter int NREG      = rob_pkg::NREG,
    localparam int TW       = $clog2(ROB_DEPTH),
    localparam int RW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          disp_valid,
    output logic          disp_ready,
    input  logic [31:0]   disp_instr,
    input  logic          disp_has_dest,
    input  logic [RW-1:0] disp_dest,
    input  logic [RW-1:0] disp_src1,
    input  logic [RW-1:0] disp_src2,
    input  logic          cmt_valid,
    input  logic          flush,
    output logic          rs_valid,
    output logic [TW-1:0] rs_tag,
    output logic [31:0]   rs_instr,
    output logic          rs_src1_busy,
    output logic          rs_src2_busy,
    output logic [TW-1:0] rs_src1_tag,
    output logic [TW-1:0] rs_src2_tag,
    output logic [TW-1:0] rob_head,
    output logic [TW-1:0] rob_tail,
    output logic [TW:0]   rob_count,
    output logic          rob_empty,
    output logic          rob_full
);
    localparam logic [TW:0] DEPTH_C = (TW+1)'(ROB_DEPTH);

    logic [TW-1:0]        head, tail;
    logic [TW:0]          count;
    logic [RW-1:0]        ent_dest [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] ent_hd;

    logic    disp_fire, cmt_fire, clr_en;
    logic    busy1, busy2;
    rename_t map1, map2;

    assign disp_ready = (count < DEPTH_C) && !flush;
    assign disp_fire  = disp_valid && disp_ready;
    assign cmt_fire   = cmt_valid && (count != '0);
    assign clr_en     = cmt_fire && ent_hd[head];

    rename_table u_rename (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx1 (disp_src1),
        .rd_idx2 (disp_src2),
        .rd_dat1 (map1),
        .rd_dat2 (map2),
        .set_en  (disp_fire && disp_has_dest),
        .set_idx (disp_dest),
        .set_tag (tail),
        .clr_en  (clr_en),
        .clr_idx (ent_dest[head]),
        .clr_tag (head),
        .flush   (flush)
    );

    // The retiring producer writes the register file on this same edge, so a
    // consumer of that tag can read the value directly instead of waiting.
    assign busy1 = map1.valid && !(clr_en && map1.tag == head);
    assign busy2 = map2.valid && !(clr_en && map2.tag == head);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_hd       <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) ent_dest[i] <= '0;
            rs_valid     <= 1'b0;
            rs_tag       <= '0;
            rs_instr     <= '0;
            rs_src1_busy <= 1'b0;
            rs_src2_busy <= 1'b0;
            rs_src1_tag  <= '0;
            rs_src2_tag  <= '0;
        end else if (flush) begin
            tail     <= head;
            count    <= '0;
            rs_valid <= 1'b0;
        end else begin
            rs_valid <= disp_fire;
            if (disp_fire) begin
                tail         <= tail + TW'(1);
                ent_hd[tail] <= disp_has_dest;
                if (disp_has_dest) ent_dest[tail] <= disp_dest;
                rs_tag       <= tail;
                rs_instr     <= disp_instr;
                rs_src1_busy <= busy1;
                rs_src2_busy <= busy2;
                rs_src1_tag  <= map1.tag;
                rs_src2_tag  <= map2.tag;
            end
            if (cmt_fire) head <= head + TW'(1);
            case ({disp_fire, cmt_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rob_head  = head;
    assign rob_tail  = tail;
    assign rob_count = count;
    assign rob_empty = (count == '0);
    assign rob_full  = (count == DEPTH_C);
endmodule

// File: tb/tb_rob_dispatch.sv
// Directed stimulus for rob_dispatch with a queue-based packet scoreboard.
// Latency: expected packets appear one edge after the dispatch handshake.
// Backpressure: stimulus only pushes an expectation for dispatches that must be accepted.
module tb_rob_dispatch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid, disp_ready, disp_has_dest;
    logic [31:0] disp_instr;
    logic [4:0]  disp_dest, disp_src1, disp_src2;
    logic        cmt_valid, flush;
    logic        rs_valid, rs_src1_busy, rs_src2_busy;
    logic [2:0]  rs_tag, rs_src1_tag, rs_src2_tag;
    logic [31:0] rs_instr;
    logic [2:0]  rob_head, rob_tail;
    logic [3:0]  rob_count;
    logic        rob_empty, rob_full;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  tag;
        logic [31:0] instr;
        logic        b1;
        logic [2:0]  t1;
        logic        b2;
        logic [2:0]  t2;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    rob_dispatch dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_instr(disp_instr),
        .disp_has_dest(disp_has_dest), .disp_dest(disp_dest),
        .disp_src1(disp_src1), .disp_src2(disp_src2),
        .cmt_valid(cmt_valid), .flush(flush),
        .rs_valid(rs_valid), .rs_tag(rs_tag), .rs_instr(rs_instr),
        .rs_src1_busy(rs_src1_busy), .rs_src2_busy(rs_src2_busy),
        .rs_src1_tag(rs_src1_tag), .rs_src2_tag(rs_src2_tag),
        .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count),
        .rob_empty(rob_empty), .rob_full(rob_full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per rs_valid pulse; tags only matter when busy.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rs_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL rs_unexpected: tag=%0d instr=%h with nothing expected", rs_tag, rs_instr);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (rs_tag !== e.tag || rs_instr !== e.instr ||
                        rs_src1_busy !== e.b1 || rs_src2_busy !== e.b2 ||
                        (e.b1 && rs_src1_tag !== e.t1) || (e.b2 && rs_src2_tag !== e.t2)) begin
                        failures++;
                        $display("FAIL rs_pkt: got tag=%0d instr=%h b1=%0b t1=%0d b2=%0b t2=%0d expected tag=%0d instr=%h b1=%0b t1=%0d b2=%0b t2=%0d",
                                 rs_tag, rs_instr, rs_src1_busy, rs_src1_tag, rs_src2_busy, rs_src2_tag,
                                 e.tag, e.instr, e.b1, e.t1, e.b2, e.t2);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [31:0] instr, input logic hd, input logic [4:0] dest,
                        input logic [4:0] s1, input logic [4:0] s2, input logic cmt,
                        input logic [2:0] etag, input logic eb1, input logic [2:0] et1,
                        input logic eb2, input logic [2:0] et2);
        exp_t e;
        e = '{tag: etag, instr: instr, b1: eb1, t1: et1, b2: eb2, t2: et2};
        sbq.push_back(e);
        disp_valid = 1'b1; disp_instr = instr; disp_has_dest = hd;
        disp_dest = dest; disp_src1 = s1; disp_src2 = s2; cmt_valid = cmt;
        step();
        disp_valid = 1'b0; cmt_valid = 1'b0;
    endtask

    task automatic commit(input int n);
        for (int k = 0; k < n; k++) begin
            cmt_valid = 1'b1;
            step();
        end
        cmt_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; disp_valid = 1'b0; disp_instr = '0; disp_has_dest = 1'b0;
        disp_dest = '0; disp_src1 = '0; disp_src2 = '0; cmt_valid = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("reset_empty", rob_empty, 1);
        chk("reset_ready", disp_ready, 1);
        chk("reset_rs_valid", rs_valid, 0);
        chk("reset_head", rob_head, 0);
        chk("reset_tail", rob_tail, 0);
        chk("reset_count", rob_count, 0);

        // Back-to-back dependency: r3<-r1+r2 then r4<-r3+r3
        disp(32'h0020_81B3, 1, 5'd3, 5'd1, 5'd2, 0, 3'd0, 0, 3'd0, 0, 3'd0);
        disp(32'h0031_8233, 1, 5'd4, 5'd3, 5'd3, 0, 3'd1, 1, 3'd0, 1, 3'd0);
        step();
        chk("pulse_one_cycle", rs_valid, 0);
        chk("b2b_count", rob_count, 2);

        // Fill with no-dest instructions, tags 2..7
        for (int i = 2; i < 8; i++)
            disp(32'hA000_0000 + i, 0, 5'd0, 5'd0, 5'd0, 0, 3'(i), 0, 3'd0, 0, 3'd0);
        chk("fill_full", rob_full, 1);
        chk("fill_ready", disp_ready, 0);
        chk("fill_tail", rob_tail, 0);

        // 9th offer while a commit fires: not accepted, commit still happens
        disp_valid = 1'b1; disp_instr = 32'hDEAD_BEEF; disp_has_dest = 1'b1; disp_dest = 5'd9;
        cmt_valid = 1'b1;
        step();
        disp_valid = 1'b0; cmt_valid = 1'b0;
        chk("nobypass_count", rob_count, 7);
        chk("nobypass_head", rob_head, 1);
        chk("nobypass_tail", rob_tail, 0);

        // Wrap: r6<-r3+r4; r3 cleared by commit of tag0, r4 still on tag1
        disp(32'h0041_8333, 1, 5'd6, 5'd3, 5'd4, 0, 3'd0, 0, 3'd0, 1, 3'd1);
        chk("wrap_tail", rob_tail, 1);
        chk("wrap_count", rob_count, 8);

        commit(7);
        chk("drain_head", rob_head, 0);
        chk("drain_count", rob_count, 1);

        disp(32'h0013_03B3, 1, 5'd7, 5'd6, 5'd1, 0, 3'd1, 1, 3'd0, 0, 3'd0);
        disp(32'hB000_0002, 0, 5'd0, 5'd7, 5'd6, 0, 3'd2, 1, 3'd1, 1, 3'd0);
        chk("sim_pre_count", rob_count, 3);

        // Dispatch + commit of tag0 (r6): commit bypass makes r6 ready
        disp(32'h0073_0433, 1, 5'd8, 5'd6, 5'd7, 1, 3'd3, 0, 3'd0, 1, 3'd1);
        chk("sim_count", rob_count, 3);
        chk("sim_head", rob_head, 1);
        chk("sim_tail", rob_tail, 4);

        // Same rename entry touched by commit (tag1,r7) and dispatch: dispatch wins
        disp(32'h0073_83B3, 1, 5'd7, 5'd7, 5'd7, 1, 3'd4, 0, 3'd0, 0, 3'd0);
        disp(32'hB000_0005, 0, 5'd0, 5'd7, 5'd8, 0, 3'd5, 1, 3'd4, 1, 3'd3);
        disp(32'hB000_0006, 0, 5'd0, 5'd0, 5'd0, 0, 3'd6, 0, 3'd0, 0, 3'd0);
        chk("preflush_count", rob_count, 5);

        // Flush with a dispatch offered
        flush = 1'b1; disp_valid = 1'b1; disp_has_dest = 1'b1; disp_dest = 5'd9;
        #1;
        chk("flush_ready", disp_ready, 0);
        step();
        flush = 1'b0; disp_valid = 1'b0;
        chk("flush_count", rob_count, 0);
        chk("flush_tail", rob_tail, 2);
        chk("flush_head", rob_head, 2);
        chk("flush_rs_valid", rs_valid, 0);
        chk("flush_empty", rob_empty, 1);
        disp(32'hC000_0002, 0, 5'd0, 5'd7, 5'd8, 0, 3'd2, 0, 3'd0, 0, 3'd0);

        // Stale mapping on r5
        disp(32'hC000_0003, 1, 5'd5, 5'd1, 5'd2, 0, 3'd3, 0, 3'd0, 0, 3'd0);
        disp(32'hC000_0004, 1, 5'd5, 5'd5, 5'd5, 0, 3'd4, 1, 3'd3, 1, 3'd3);
        disp(32'hC000_0005, 0, 5'd0, 5'd5, 5'd0, 0, 3'd5, 1, 3'd4, 0, 3'd0);
        commit(2);
        disp(32'hC000_0006, 0, 5'd0, 5'd5, 5'd5, 0, 3'd6, 1, 3'd4, 1, 3'd4);
        commit(1);
        disp(32'hC000_0007, 0, 5'd0, 5'd5, 5'd5, 0, 3'd7, 0, 3'd0, 0, 3'd0);
        chk("stale_count", rob_count, 3);

        commit(3);
        chk("empty_head", rob_head, 0);
        chk("empty_flag", rob_empty, 1);
        commit(1);
        chk("cmt_empty_count", rob_count, 0);
        chk("cmt_empty_head", rob_head, 0);

        // Asynchronous reset while a packet is being presented
        disp(32'hE000_0000, 1, 5'd10, 5'd0, 5'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0);
        #5;
        rst_n = 1'b0;
        #1;
        chk("areset_rs_valid", rs_valid, 0);
        chk("areset_count", rob_count, 0);
        chk("areset_tail", rob_tail, 0);
        chk("areset_ready", disp_ready, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        step();
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
